stage_mem: RTL and testbench
============================

STAGE_MEM -- requirements
Module: stage_MEM

Interface
- REQ-001: Parameter REG_WIDTH, default 32, datapath width; SHALL be 32 because the byte-lane logic is fixed at four lanes.
- REQ-002: clk  input  1  single clock; all state updates on rising edge.
- REQ-003: reset  input  1  asynchronous, active-high reset.
- REQ-004: ex_valid  input  1  EX result valid this cycle.
- REQ-005: ex_alu_out  input  REG_WIDTH  ALU result / effective address.
- REQ-006: ex_store_data  input  REG_WIDTH  forwarded rs2 store data.
- REQ-007: ex_mem_read, ex_mem_write  input  1 each  load / store request.
- REQ-008: ex_funct3  input  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- REQ-009: ex_rd  input  5  destination register; ex_reg_write  input  1  writeback enable.
- REQ-010: mem_stall  output  1  EX/MEM register busy; upstream holds its outputs.
- REQ-011: mem_fwd_data  output  REG_WIDTH  captured ALU result, fed back to EX as EX_MEM_alu_out.
- REQ-012: dmem_req, dmem_we  output  1 each  data memory request / write enable.
- REQ-013: dmem_addr  output  REG_WIDTH  word-aligned address.
- REQ-014: dmem_wdata  output  REG_WIDTH  lane-aligned store data; dmem_be  output  4  byte enables.
- REQ-015: dmem_rdata  input  REG_WIDTH  read word; dmem_ack  input  1  access complete.
- REQ-016: wb_valid, wb_reg_write  output  1 each; wb_data  output  REG_WIDTH; wb_rd  output  5.
- REQ-017: mem_err  output  1  misaligned or illegal-size access.

Function
- REQ-018: Capture of all ex_* inputs into the EX/MEM register SHALL occur on a rising edge where ex_valid=1 and mem_stall=0.
- REQ-019: FSM states SHALL be IDLE and WAIT; mem_stall SHALL equal (state==WAIT), combinationally.
- REQ-020: Non-memory op: wb_valid=1 the cycle after capture, wb_data=ALU result, wb_rd and wb_reg_write as captured.
- REQ-021: Aligned memory op: state IDLE->WAIT on capture; dmem_req=1 throughout WAIT with addr, we, wdata and be held stable.
- REQ-022: dmem_ack sampled high in WAIT: state->IDLE, dmem_req=0 and wb_valid=1 on the next cycle; minimum latency is 2 cycles.
- REQ-023: dmem_ack outside WAIT SHALL be ignored.
- REQ-024: dmem_addr = {ALU[31:2],2'b00}; dmem_we=1 only for stores.
- REQ-025: Store lane mapping:
  - SB: be=1<<addr[1:0], wdata = byte replicated to all four lanes.
  - SH: be=0011 when addr[1]=0, 1100 when addr[1]=1; wdata = halfword replicated.
  - SW: be=1111.
  - Loads: be=1111.
- REQ-026: Load data SHALL select the addressed byte/halfword, sign-extend for B/H, zero-extend for BU/HU, and pass W unchanged.
- REQ-027: Store completion: wb_valid=1, wb_reg_write=0.
- REQ-028: Error condition: H/HU with addr[0]=1, W with addr[1:0]!=0, or funct3 in {011,110,111} on a memory op. In that case:
  - no dmem_req is issued and the FSM stays IDLE;
  - the next cycle carries wb_valid=1, mem_err=1, wb_reg_write=0 for one cycle.
- REQ-029: ex_mem_read and ex_mem_write both set: the op SHALL be handled as a store with wb_reg_write=0.
- REQ-030: wb_valid and mem_err SHALL be single-cycle pulses per captured op.
- REQ-031: mem_fwd_data SHALL hold the captured ALU result until the next capture.

Reset
- REQ-032: reset=1 SHALL asynchronously force:
  - state=IDLE;
  - dmem_req, dmem_we, wb_valid, wb_reg_write, mem_err, mem_stall = 0;
  - dmem_be = 0000;
  - all data/address outputs and wb_rd = 0.
- REQ-033: Reset during WAIT SHALL abandon the access; an ack arriving after reset deasserts SHALL be ignored.

Verification
- REQ-034: Non-memory op, ALU=0x0000_1234, rd=5 -> one cycle later: wb_valid=1, wb_data=0x0000_1234, wb_rd=5, mem_stall=0.
- REQ-035: LB addr 0x103, dmem_rdata=0x80FF_FFFF, ack on the 3rd WAIT cycle:
  - dmem_addr=0x100 and mem_stall=1 for 3 cycles;
  - then wb_data=0xFFFF_FF80.
- REQ-036: SH addr 0x202, data 0x0000_ABCD -> dmem_addr=0x200, be=1100, wdata=0xABCD_ABCD, we=1; completion has wb_reg_write=0.
- REQ-037: LW addr 0x101 -> no dmem_req; next cycle wb_valid=1, mem_err=1, wb_reg_write=0.
- REQ-038: ex_valid held high while in WAIT -> no new capture and mem_fwd_data unchanged until one cycle after ack.
- REQ-039: Reset asserted mid-WAIT, then ack pulsed after release -> dmem_req=0 immediately; no wb_valid produced.

Source files
------------

// File: rtl/stage_mem.sv
// stage_mem: EX/MEM pipeline register and data-memory access stage.
// Handles byte/halfword/word loads and stores with one outstanding request at a time.
module stage_mem #(
    parameter int REG_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ex_valid,
    input  logic [REG_WIDTH-1:0] ex_alu_out,
    input  logic [REG_WIDTH-1:0] ex_store_data,
    input  logic                 ex_mem_read,
    input  logic                 ex_mem_write,
    input  logic [2:0]           ex_funct3,
    input  logic [4:0]           ex_rd,
    input  logic                 ex_reg_write,
    output logic                 mem_stall,
    output logic [REG_WIDTH-1:0] mem_fwd_data,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [REG_WIDTH-1:0] dmem_addr,
    output logic [REG_WIDTH-1:0] dmem_wdata,
    output logic [3:0]           dmem_be,
    input  logic [REG_WIDTH-1:0] dmem_rdata,
    input  logic                 dmem_ack,
    output logic                 wb_valid,
    output logic                 wb_reg_write,
    output logic [REG_WIDTH-1:0] wb_data,
    output logic [4:0]           wb_rd,
    output logic                 mem_err
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t      state_r;
    logic [2:0]  funct3_r;
    logic [4:0]  rd_r;
    logic        load_wr_r;
    logic        capture_s;
    logic        is_mem_s;
    logic        access_err_s;

    // Byte enables for a store; size comes from funct3[1:0], loads always read the full word.
    function automatic logic [3:0] lane_be(input logic [2:0] funct3, input logic [1:0] addr_lo,
                                           input logic is_store);
        logic [3:0] be;
        if (!is_store) begin
            be = 4'b1111;
        end else begin
            case (funct3[1:0])
                2'b00:   be = 4'b0001 << addr_lo;
                2'b01:   be = addr_lo[1] ? 4'b1100 : 4'b0011;
                default: be = 4'b1111;
            endcase
        end
        return be;
    endfunction

    // Replicate store data across lanes so the byte enables alone pick the target bytes.
    function automatic logic [31:0] lane_wdata(input logic [2:0] funct3, input logic [31:0] data);
        logic [31:0] wd;
        case (funct3[1:0])
            2'b00:   wd = {4{data[7:0]}};
            2'b01:   wd = {2{data[15:0]}};
            default: wd = data;
        endcase
        return wd;
    endfunction

    // Extract and extend the addressed byte/halfword from the returned word.
    function automatic logic [31:0] load_extract(input logic [2:0] funct3, input logic [1:0] addr_lo,
                                                 input logic [31:0] rdata);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res;
        case (addr_lo)
            2'b00:   byte_v = rdata[7:0];
            2'b01:   byte_v = rdata[15:8];
            2'b10:   byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
        half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            3'b000:  res = {{24{byte_v[7]}}, byte_v};
            3'b100:  res = {24'h00_0000, byte_v};
            3'b001:  res = {{16{half_v[15]}}, half_v};
            3'b101:  res = {16'h0000, half_v};
            default: res = rdata;
        endcase
        return res;
    endfunction

    assign mem_stall = (state_r == WAIT);

    // Capture qualification and misalignment / illegal-size detection on the incoming op.
    always_comb begin
        capture_s    = ex_valid && !mem_stall;
        is_mem_s     = ex_mem_read || ex_mem_write;
        access_err_s = 1'b0;
        if (is_mem_s) begin
            case (ex_funct3)
                3'b000, 3'b100: access_err_s = 1'b0;
                3'b001, 3'b101: access_err_s = ex_alu_out[0];
                3'b010:         access_err_s = (ex_alu_out[1:0] != 2'b00);
                default:        access_err_s = 1'b1;
            endcase
        end else begin
            access_err_s = 1'b0;
        end
    end

    // EX/MEM register, access FSM and registered memory / writeback outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            funct3_r     <= 3'b000;
            rd_r         <= 5'd0;
            load_wr_r    <= 1'b0;
            mem_fwd_data <= 32'h0000_0000;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= 32'h0000_0000;
            dmem_wdata   <= 32'h0000_0000;
            dmem_be      <= 4'b0000;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_data      <= 32'h0000_0000;
            wb_rd        <= 5'd0;
            mem_err      <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            mem_err      <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (capture_s) begin
                        mem_fwd_data <= ex_alu_out;
                        funct3_r     <= ex_funct3;
                        rd_r         <= ex_rd;
                        // Read+write together is treated as a store, so it never writes back.
                        load_wr_r    <= ex_reg_write && !ex_mem_write;
                        if (!is_mem_s) begin
                            wb_valid     <= 1'b1;
                            wb_data      <= ex_alu_out;
                            wb_rd        <= ex_rd;
                            wb_reg_write <= ex_reg_write;
                        end else if (access_err_s) begin
                            wb_valid <= 1'b1;
                            mem_err  <= 1'b1;
                            wb_data  <= ex_alu_out;
                            wb_rd    <= ex_rd;
                        end else begin
                            state_r    <= WAIT;
                            dmem_req   <= 1'b1;
                            dmem_we    <= ex_mem_write;
                            dmem_addr  <= {ex_alu_out[31:2], 2'b00};
                            dmem_be    <= lane_be(ex_funct3, ex_alu_out[1:0], ex_mem_write);
                            dmem_wdata <= lane_wdata(ex_funct3, ex_store_data);
                        end
                    end
                end
                WAIT: begin
                    if (dmem_ack) begin
                        state_r      <= IDLE;
                        dmem_req     <= 1'b0;
                        dmem_we      <= 1'b0;
                        wb_valid     <= 1'b1;
                        wb_rd        <= rd_r;
                        wb_reg_write <= load_wr_r;
                        wb_data      <= dmem_we ? mem_fwd_data
                                                : load_extract(funct3_r, mem_fwd_data[1:0], dmem_rdata);
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_mem.sv
// Directed self-checking bench for stage_mem: ALU passthrough, loads, stores,
// misaligned accesses, stall behaviour and reset during an outstanding access.
module tb_stage_mem;

    logic        clk;
    logic        reset;
    logic        ex_valid;
    logic [31:0] ex_alu_out;
    logic [31:0] ex_store_data;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        mem_stall;
    logic [31:0] mem_fwd_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        mem_err;

    int checks_r;
    int errors_r;

    stage_mem #(.REG_WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .ex_valid     (ex_valid),
        .ex_alu_out   (ex_alu_out),
        .ex_store_data(ex_store_data),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_funct3    (ex_funct3),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .mem_stall    (mem_stall),
        .mem_fwd_data (mem_fwd_data),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_be      (dmem_be),
        .dmem_rdata   (dmem_rdata),
        .dmem_ack     (dmem_ack),
        .wb_valid     (wb_valid),
        .wb_reg_write (wb_reg_write),
        .wb_data      (wb_data),
        .wb_rd        (wb_rd),
        .mem_err      (mem_err)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_r = checks_r + 1;
        if (obs !== exp) begin
            errors_r = errors_r + 1;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] alu, input logic [31:0] sd, input logic rd_en,
                         input logic wr_en, input logic [2:0] f3, input logic [4:0] rd,
                         input logic rw);
        ex_valid      = 1'b1;
        ex_alu_out    = alu;
        ex_store_data = sd;
        ex_mem_read   = rd_en;
        ex_mem_write  = wr_en;
        ex_funct3     = f3;
        ex_rd         = rd;
        ex_reg_write  = rw;
    endtask

    // Issue a load, ack it in the first WAIT cycle, check the extended result.
    task automatic load_ack1(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                             input logic [31:0] rdata, input logic [31:0] exp);
        issue(addr, 32'h0, 1'b1, 1'b0, f3, 5'd9, 1'b1);
        step();
        ex_valid   = 1'b0;
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        step();
        dmem_ack = 1'b0;
        chk({tag, "_valid"}, {31'd0, wb_valid}, 32'd1);
        chk({tag, "_data"}, wb_data, exp);
    endtask

    initial begin
        checks_r      = 0;
        errors_r      = 0;
        reset         = 1'b1;
        ex_valid      = 1'b0;
        ex_alu_out    = 32'h0;
        ex_store_data = 32'h0;
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b0;
        ex_funct3     = 3'b000;
        ex_rd         = 5'd0;
        ex_reg_write  = 1'b0;
        dmem_rdata    = 32'h0;
        dmem_ack      = 1'b0;

        #3;
        chk("rst_stall", {31'd0, mem_stall}, 32'd0);
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_wbv", {31'd0, wb_valid}, 32'd0);
        chk("rst_be", {28'd0, dmem_be}, 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_fwd", mem_fwd_data, 32'd0);
        step();
        step();
        reset = 1'b0;

        // Ack while idle is ignored.
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk("idle_ack_wbv", {31'd0, wb_valid}, 32'd0);
        chk("idle_ack_stall", {31'd0, mem_stall}, 32'd0);

        // Non-memory op.
        issue(32'h0000_1234, 32'h0, 1'b0, 1'b0, 3'b000, 5'd5, 1'b1);
        step();
        ex_valid = 1'b0;
        chk("alu_wbv", {31'd0, wb_valid}, 32'd1);
        chk("alu_data", wb_data, 32'h0000_1234);
        chk("alu_rd", {27'd0, wb_rd}, 32'd5);
        chk("alu_rw", {31'd0, wb_reg_write}, 32'd1);
        chk("alu_stall", {31'd0, mem_stall}, 32'd0);
        chk("alu_fwd", mem_fwd_data, 32'h0000_1234);
        step();
        chk("alu_pulse", {31'd0, wb_valid}, 32'd0);

        // LB 0x103 with ack in the 3rd WAIT cycle; a new op is held on ex_* throughout.
        issue(32'h0000_0103, 32'h0, 1'b1, 1'b0, 3'b000, 5'd7, 1'b1);
        step();
        issue(32'h5555_0000, 32'h0, 1'b0, 1'b0, 3'b000, 5'd3, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            chk($sformatf("lb_w%0d_stall", i), {31'd0, mem_stall}, 32'd1);
            chk($sformatf("lb_w%0d_addr", i), dmem_addr, 32'h0000_0100);
            chk($sformatf("lb_w%0d_req", i), {31'd0, dmem_req}, 32'd1);
            chk($sformatf("lb_w%0d_fwd", i), mem_fwd_data, 32'h0000_0103);
            if (i == 3) begin
                dmem_ack   = 1'b1;
                dmem_rdata = 32'h80FF_FFFF;
            end
            step();
        end
        dmem_ack = 1'b0;
        chk("lb_wbv", {31'd0, wb_valid}, 32'd1);
        chk("lb_data", wb_data, 32'hFFFF_FF80);
        chk("lb_rd", {27'd0, wb_rd}, 32'd7);
        chk("lb_rw", {31'd0, wb_reg_write}, 32'd1);
        chk("lb_req_off", {31'd0, dmem_req}, 32'd0);
        chk("lb_stall_off", {31'd0, mem_stall}, 32'd0);
        chk("lb_fwd_hold", mem_fwd_data, 32'h0000_0103);
        step();
        ex_valid = 1'b0;
        chk("held_fwd", mem_fwd_data, 32'h5555_0000);
        chk("held_wbv", {31'd0, wb_valid}, 32'd1);
        chk("held_data", wb_data, 32'h5555_0000);

        // SH 0x202; reg_write requested but a store never writes back.
        issue(32'h0000_0202, 32'h0000_ABCD, 1'b0, 1'b1, 3'b001, 5'd4, 1'b1);
        step();
        ex_valid = 1'b0;
        chk("sh_addr", dmem_addr, 32'h0000_0200);
        chk("sh_be", {28'd0, dmem_be}, 32'h0000_000C);
        chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
        chk("sh_we", {31'd0, dmem_we}, 32'd1);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk("sh_wbv", {31'd0, wb_valid}, 32'd1);
        chk("sh_rw", {31'd0, wb_reg_write}, 32'd0);
        chk("sh_req_off", {31'd0, dmem_req}, 32'd0);

        // SB 0x001 with both read and write set: handled as a store.
        issue(32'h0000_0001, 32'h1234_567A, 1'b1, 1'b1, 3'b000, 5'd6, 1'b1);
        step();
        ex_valid = 1'b0;
        chk("sb_be", {28'd0, dmem_be}, 32'h0000_0002);
        chk("sb_wdata", dmem_wdata, 32'h7A7A_7A7A);
        chk("sb_we", {31'd0, dmem_we}, 32'd1);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk("sb_wbv", {31'd0, wb_valid}, 32'd1);
        chk("sb_rw", {31'd0, wb_reg_write}, 32'd0);

        // Load extraction variants.
        load_ack1("lh", 32'h0000_0002, 3'b001, 32'h8765_4321, 32'hFFFF_8765);
        load_ack1("lhu", 32'h0000_0002, 3'b101, 32'h8765_4321, 32'h0000_8765);
        load_ack1("lbu", 32'h0000_0001, 3'b100, 32'h8765_4321, 32'h0000_0043);
        load_ack1("lw", 32'h0000_0010, 3'b010, 32'h8765_4321, 32'h8765_4321);

        // Misaligned LW 0x101.
        issue(32'h0000_0101, 32'h0, 1'b1, 1'b0, 3'b010, 5'd8, 1'b1);
        step();
        ex_valid = 1'b0;
        chk("lw_mis_req", {31'd0, dmem_req}, 32'd0);
        chk("lw_mis_stall", {31'd0, mem_stall}, 32'd0);
        chk("lw_mis_wbv", {31'd0, wb_valid}, 32'd1);
        chk("lw_mis_err", {31'd0, mem_err}, 32'd1);
        chk("lw_mis_rw", {31'd0, wb_reg_write}, 32'd0);
        step();
        chk("lw_mis_err_pulse", {31'd0, mem_err}, 32'd0);
        chk("lw_mis_wbv_pulse", {31'd0, wb_valid}, 32'd0);

        // Illegal funct3 011 on an aligned address.
        issue(32'h0000_0000, 32'h0, 1'b1, 1'b0, 3'b011, 5'd8, 1'b1);
        step();
        ex_valid = 1'b0;
        chk("ill_err", {31'd0, mem_err}, 32'd1);
        chk("ill_req", {31'd0, dmem_req}, 32'd0);

        // Reset in the middle of WAIT, then a late ack.
        issue(32'h0000_0300, 32'h0, 1'b1, 1'b0, 3'b010, 5'd2, 1'b1);
        step();
        ex_valid = 1'b0;
        chk("rw_req_on", {31'd0, dmem_req}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rw_req_off", {31'd0, dmem_req}, 32'd0);
        chk("rw_stall_off", {31'd0, mem_stall}, 32'd0);
        step();
        reset    = 1'b0;
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk("rw_late_wbv", {31'd0, wb_valid}, 32'd0);
        chk("rw_late_req", {31'd0, dmem_req}, 32'd0);
        step();
        chk("rw_late_wbv2", {31'd0, wb_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule
